rr_grant_sched16: RTL and testbench



---
 rtl/grant_pkg.sv | 12 +
 rtl/onehot_dec4to16.sv | 12 +
 rtl/rr_grant_sched16.sv | 100 ++++++++++
 tb/tb_rr_grant_sched16.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/grant_pkg.sv
// Shared types and sizes for the 16-way round-robin grant scheduler.
package grant_pkg;
    localparam int NREQ  = 16;
    localparam int IDX_W = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/onehot_dec4to16.sv
// Pure combinational 4-bit index to 16-bit one-hot decoder.
module onehot_dec4to16
    import grant_pkg::*;
(
    input  idx_t            idx,
    output logic [NREQ-1:0] onehot
);
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/rr_grant_sched16.sv
// Round-robin grant scheduler: picks the next requester after the last winner,
// holds the grant until done, withdrawal or timeout, then re-arbitrates.
module rr_grant_sched16
    import grant_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);
    localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    idx_t            ptr_q, ptr_d;
    idx_t            gnt_idx_q, gnt_idx_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic            timeout_q, timeout_d;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    idx_t              pe_idx;
    idx_t              pick_idx;
    logic              rel_done, rel_wd, rel_to;
    logic [NREQ-1:0]   dec_out;

    // Rotate so bit 0 is the requester at ptr, find the lowest set bit,
    // then undo the rotation with a mod-16 add.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr_q +: NREQ];
        pe_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) pe_idx = idx_t'(i);
        end
        pick_idx = ptr_q + pe_idx;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        rel_done   = done;
        rel_wd     = ~req[gnt_idx_q];
        rel_to     = (hold_cnt_q == HOLD_MAX);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d  = pick_idx;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || rel_wd || rel_to) begin
                    ptr_d     = gnt_idx_q + idx_t'(1);
                    state_d   = IDLE;
                    // Only flag a timeout when nothing else would have released.
                    timeout_d = rel_to && !rel_done && !rel_wd;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    onehot_dec4to16 u_dec (
        .idx    (gnt_idx_q),
        .onehot (dec_out)
    );

    assign gnt_valid = (state_q == GRANT);
    assign gnt       = gnt_valid ? dec_out : '0;
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_grant_sched16.sv
// Scoreboard bench: each stimulus pushes the grant it expects (index, length,
// timeout flag); a negedge monitor pops and compares when a grant completes.
module tb_rr_grant_sched16;
    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    typedef struct {
        logic [3:0] idx;
        int         len;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en;

    rr_grant_sched16 #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Grant tracker: measures each grant's length and checks the timeout pulse
    // in the first cycle after it ends.
    logic        prev_v = 1'b0;
    logic [3:0]  cur_idx;
    logic [15:0] cur_gnt;
    int          cur_len;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            prev_v = 1'b0;
        end else begin
            if (gnt_valid) begin
                if (!prev_v) begin
                    cur_idx = gnt_idx;
                    cur_gnt = gnt;
                    cur_len = 1;
                end else begin
                    cur_len++;
                end
                chk("to_in_grant", 32'(timeout), 32'd0);
            end else if (prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 32'(cur_idx), 32'hFFFF);
                end else begin
                    exp_t e;
                    logic [15:0] oh;
                    e  = exp_q.pop_front();
                    oh = 16'h1 << e.idx;
                    chk("gnt_idx", 32'(cur_idx), 32'(e.idx));
                    chk("gnt_vec", 32'(cur_gnt), 32'(oh));
                    chk("gnt_len", 32'(cur_len), 32'(e.len));
                    chk("to_pulse", 32'(timeout), 32'(e.to));
                end
            end else begin
                chk("to_idle", 32'(timeout), 32'd0);
            end
            prev_v = gnt_valid;
        end
    end

    task automatic wait_gnt(output int waited);
        waited = 0;
        while (!gnt_valid && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!gnt_valid) chk("wait_gnt_timeout", 32'd0, 32'd1);
    endtask

    // Grant held for h+1 cycles, ended by a one-cycle done pulse.
    task automatic grant_done(input logic [15:0] r, input logic [3:0] idx,
                              input int h, output int waited);
        exp_t e;
        req   = r;
        e.idx = idx; e.len = h + 1; e.to = 1'b0;
        exp_q.push_back(e);
        wait_gnt(waited);
        repeat (h) begin @(posedge clk); #1; end
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    initial begin
        int   w;
        int   n;
        exp_t e;
        rst_n  = 1'b1;
        req    = '0;
        done   = 1'b0;
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Rotation with all requesting: 0..15 then wrap to 0, one idle between.
        for (int i = 0; i < 17; i++) begin
            grant_done(16'hFFFF, 4'(i % 16), i % 4, w);
            chk("rot_gap", 32'(w), 32'd1);
        end
        req = '0;

        // Priority skip: after granting 5, ptr=6 so 0 wins before 5.
        grant_done(16'h0020, 4'd5, 0, w);
        grant_done(16'h0021, 4'd0, 1, w);
        grant_done(16'h0021, 4'd5, 2, w);

        // Timeout with done never asserted.
        req = 16'h0100;
        e.idx = 4'd8; e.len = 8; e.to = 1'b1;
        exp_q.push_back(e);
        wait_gnt(w);
        n = 0;
        while (gnt_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("to_release", 32'(gnt_valid), 32'd0);
        // ptr must now be 9: with 8 and 9 both requesting, 9 wins.
        grant_done(16'h0300, 4'd9, 0, w);
        // done on the 8th cycle suppresses the pulse.
        grant_done(16'h0100, 4'd8, 7, w);

        // Withdrawal after 2 cycles.
        req = 16'h0008;
        e.idx = 4'd3; e.len = 2; e.to = 1'b0;
        exp_q.push_back(e);
        wait_gnt(w);
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
        chk("wd_release", 32'(gnt), 32'd0);
        // ptr must now be 4: with 3 and 4 both requesting, 4 wins.
        grant_done(16'h0018, 4'd4, 0, w);
        req = '0;

        // Idle stability.
        repeat (20) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 32'd0);
            chk("idle_valid", 32'(gnt_valid), 32'd0);
            chk("idle_idx", 32'(gnt_idx), 32'd4);
        end

        // Reset in the middle of a grant.
        @(posedge clk); #1;
        mon_en = 1'b0;
        req = 16'h0020;
        wait_gnt(w);
        chk("pre_rst_idx", 32'(gnt_idx), 32'd5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_valid", 32'(gnt_valid), 32'd0);
        chk("midrst_idx", 32'(gnt_idx), 32'd0);
        chk("midrst_to", 32'(timeout), 32'd0);
        req = '0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        // ptr back to 0: of 0 and 15, 0 wins.
        grant_done(16'h8001, 4'd0, 1, w);
        req = '0;

        repeat (4) @(posedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
